bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) method. It is the inverse of the calculator's BCD-to-binary core. It takes an unsigned binary result from the ALU path and produces packed BCD digits for the display/formatting path. It uses a start/busy/done handshake and a fixed, deterministic latency.

---
 rtl/bin2bcd_seq_if.sv | 10 +
 rtl/bin2bcd_seq.sv | 84 ++++++++
 tb/tb_bin2bcd_seq.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: start/busy/done handshake and data bus for the binary-to-BCD converter
interface bin2bcd_seq_if #(parameter int WIDTH = 16, parameter int DIGITS = 5);
  logic start;
  logic [WIDTH-1:0] bin_in;
  logic busy;
  logic done;
  logic [DIGITS*4-1:0] bcd_out;
  modport master (output start, bin_in, input busy, done, bcd_out);
  modport slave (input start, bin_in, output busy, done, bcd_out);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter with start/busy/done handshake
// Define BIN2BCD_FAST_EN to merge add-3 and shift into one cycle per bit.
module bin2bcd_seq #(
  parameter int WIDTH = 16,
  parameter int DIGITS = 5
) (
  input logic clk,
  input logic rst,
  bin2bcd_seq_if.slave bus
);
  localparam int BW = DIGITS * 4;
`ifdef BIN2BCD_FAST_EN
  // SHIFT applies add-3 and the shift in the same cycle
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam state_t S_LOOP = SHIFT;
`else
  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;
  localparam state_t S_LOOP = ADD;
`endif
  state_t r_state;
  logic [BW-1:0] r_bcd_acc, r_bcd_out, w_add;
  logic [WIDTH-1:0] r_bin_acc;
  logic [4:0] r_cnt;
  logic r_busy, r_done;
  logic [BW+WIDTH-1:0] w_sh;
  logic w_last;
  genvar d;
  for (d = 0; d < DIGITS; d++) begin : g_dig
    assign w_add[4*d+:4] = (r_bcd_acc[4*d+:4] >= 4'd5) ? r_bcd_acc[4*d+:4] + 4'd3 : r_bcd_acc[4*d+:4];
  end
`ifdef BIN2BCD_FAST_EN
  assign w_sh = {w_add, r_bin_acc} << 1;
`else
  assign w_sh = {r_bcd_acc, r_bin_acc} << 1;
`endif
  assign w_last = r_cnt == 5'(WIDTH - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_bcd_acc <= '0;
      r_bin_acc <= '0;
      r_cnt <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_bcd_out <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_bin_acc <= bus.bin_in;
          r_bcd_acc <= '0;
          r_cnt <= '0;
          r_busy <= 1'b1;
          r_state <= S_LOOP;
        end
`ifndef BIN2BCD_FAST_EN
        ADD: begin
          r_bcd_acc <= w_add;
          r_state <= SHIFT;
        end
`endif
        SHIFT: begin
          {r_bcd_acc, r_bin_acc} <= w_sh;
          if (w_last) begin
            r_bcd_out <= w_sh[BW+WIDTH-1 -: BW];
            r_done <= 1'b1;
            r_busy <= 1'b0;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 5'd1;
            r_state <= S_LOOP;
          end
        end
        DONE: begin
          r_done <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.bcd_out = r_bcd_out;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;
`ifdef BIN2BCD_FAST_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 32;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  bin2bcd_seq_if #(.WIDTH(16), .DIGITS(5)) bus ();
  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    int p;
    p = 1;
    for (int k = 0; k < 5; k++) begin
      r[4*k+:4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction
  task automatic conv(input string tag, input logic [15:0] v, input logic [19:0] exp, input bit disturb);
    int n;
    bit busy_bad;
    n = 0;
    busy_bad = 0;
    bus.start = 1'b1;
    bus.bin_in = v;
    tick();
    bus.start = disturb;
    bus.bin_in = disturb ? 16'd1 : v;
    while (!bus.done && n < LAT + 8) begin
      if (bus.busy !== 1'b1) busy_bad = 1;
      tick();
      n++;
    end
    bus.start = 1'b0;
    chk({tag, "_busy"}, 32'(busy_bad), 32'd0);
    chk({tag, "_lat"}, 32'(n), 32'(LAT));
    chk({tag, "_bcd"}, 32'(bus.bcd_out), 32'(exp));
    chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    tick();
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
  endtask
  initial begin
    int pulses, t1, t2;
    logic [19:0] v1, v2;
    bit early;
    bus.start = 1'b0;
    bus.bin_in = '0;
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_bcd", 32'(bus.bcd_out), 32'd0);
    rst = 1'b0;
    tick();
    conv("zero", 16'd0, 20'h00000, 1'b0);
    conv("max", 16'd65535, 20'h65535, 1'b0);
    conv("ignore", 16'd4095, 20'h04095, 1'b1);
    // back-to-back with start held high across the first completion
    pulses = 0; t1 = 0; t2 = 0; v1 = '0; v2 = '0;
    bus.start = 1'b1;
    bus.bin_in = 16'd9999;
    tick();
    bus.bin_in = 16'd1234;
    for (int c = 1; c <= 2 * LAT + 4; c++) begin
      tick();
      if (bus.done) begin
        pulses++;
        if (pulses == 1) begin t1 = c; v1 = bus.bcd_out; end
        else begin t2 = c; v2 = bus.bcd_out; bus.start = 1'b0; end
      end
    end
    bus.start = 1'b0;
    chk("b2b_pulses", 32'(pulses), 32'd2);
    chk("b2b_t1", 32'(t1), 32'(LAT));
    chk("b2b_v1", 32'(v1), 32'h09999);
    chk("b2b_t2", 32'(t2), 32'(2 * LAT + 2));
    chk("b2b_v2", 32'(v2), 32'h01234);
    tick();
    tick();
    // reset aborts a conversion at E0+10
    bus.start = 1'b1;
    bus.bin_in = 16'd500;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    rst = 1'b1;
    tick();
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_bcd", 32'(bus.bcd_out), 32'd0);
    rst = 1'b0;
    early = 0;
    for (int c = 0; c < LAT + 4; c++) begin
      tick();
      if (bus.done || bus.busy) early = 1;
    end
    chk("abort_quiet", 32'(early), 32'd0);
    conv("fresh500", 16'd500, 20'h00500, 1'b0);
    conv("b9", 16'd9, ref_bcd(9), 1'b0);
    conv("b10", 16'd10, ref_bcd(10), 1'b0);
    conv("b99", 16'd99, 20'h00099, 1'b0);
    conv("b100", 16'd100, 20'h00100, 1'b0);
    conv("b10000", 16'd10000, 20'h10000, 1'b0);
    conv("b65534", 16'd65534, 20'h65534, 1'b0);
    for (int i = 0; i < 150; i++) begin
      int v;
      v = (i * 439 + 7) % 65536;
      conv("sweep", 16'(v), ref_bcd(v), 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
